spectrum_line_feeder: RTL
=========================

Name: spectrum_line_feeder

Overview:
- Producer side of the spectrum-drawing handshake. Buffers one frame of FFT magnitude bins and supplies the current frequency point (line_cnt) and scaled bar length (line_length) to the LCD spectrum renderer.
- Responds to the renderer's data_req (fetch the next bin) and wr_over (bar finished; advance the point).
- Ping-pong buffering keeps the displayed frame stable while the FFT writes a new one.
- Sits between the FIR/FFT magnitude path and the LCD display block, all in the lcd_clk domain.

Parameters:
- POINT_NUM, 128: number of bins displayed; power of two, max 128.
- H_LCD_DISP, 480: horizontal resolution; line_length is clamped to H_LCD_DISP-1.
- MAG_SHIFT, 0: right shift applied to the magnitude before clamping.
- DECAY, 2: peak decay step per refresh; used only with PEAK_HOLD_EN.

Ports:
- lcd_clk  in  1  LCD drive clock; the only clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- fft_valid  in  1  magnitude sample valid.
- fft_sop  in  1  marks bin 0 of a frame; qualified by fft_valid.
- fft_mag  in  16  unsigned bin magnitude.
- data_req  in  1  one-cycle pulse from the renderer: fetch data for line_cnt.
- wr_over  in  1  one-cycle pulse from the renderer: current bar finished.
- line_cnt  out  7  current frequency point index.
- line_length  out  16  bar length in pixels.
- frame_drop  out  1  one-cycle pulse when an incoming FFT frame is discarded.

Behaviour:
- Reset (async, sys_rst_n low) clears:
  - line_cnt=0, line_length=0, frame_drop=0.
  - wr_bank=0, rd_bank=1, ready=0, write FSM to IDLE.
  - Under PEAK_HOLD_EN, all peak entries=0.
- Storage: two banks of POINT_NUM x 16 (RAM, one-cycle read latency).
- Write FSM: IDLE, FILL, DONE.
  - IDLE: on fft_valid&fft_sop with ready=0, write fft_mag to wr_bank[0], wr_addr=1, go to FILL. If ready=1, pulse frame_drop and stay IDLE; the whole frame is discarded.
  - FILL: each fft_valid writes to wr_bank[wr_addr] and increments wr_addr. After address POINT_NUM-1 is written, set ready=1 and go to DONE.
  - FILL, restart: fft_valid&fft_sop restarts at address 0 (short frame abandoned, no drop pulse).
  - DONE: samples ignored until the next sop; then behaves as IDLE.
- Read path, on data_req:
  - Cycle 0: RAM read of rd_bank[line_cnt].
  - Cycle 1: s = mag >> MAG_SHIFT; clamp to H_LCD_DISP-1 if s > H_LCD_DISP-1.
  - Cycle 2: line_length registered (latency 2 cycles from data_req).
  - line_length holds its value between requests.
- Advance, on wr_over:
  - If line_cnt < POINT_NUM-1: line_cnt+1.
  - Else: line_cnt wraps to 0. If ready=1, swap wr_bank/rd_bank and clear ready. The swap happens only at this wrap, so a displayed frame is never mixed.
- Simultaneous events:
  - ready being set in the same cycle as the wrap: no swap; the swap is taken at the next wrap.
  - data_req and wr_over in the same cycle: wr_over wins the counter update; the read uses the pre-increment line_cnt.
  - A write and a read never target the same bank.
- Reset mid-frame: all of the above state is cleared and any partial frame is lost.

Optional Feature:
- Macro: PEAK_HOLD_EN.
- Defined:
  - A POINT_NUM x 16 peak array is added.
  - At read cycle 1, with clamped s and p=peak[line_cnt]:
    - If s >= p: new=s.
    - Else: new = p-DECAY, saturating at 0.
  - peak[line_cnt]=new and line_length=new.
  - Latency stays 2 cycles.
- Undefined: line_length is the clamped s; no peak storage is instantiated.

Test Plan:
- Reset release, no FFT data, data_req then wr_over repeated 128 times -> line_length=0 throughout; line_cnt steps 0..127 then returns to 0.
- Write frame with fft_mag[k]=k*3 (MAG_SHIFT=0), then complete one display wrap -> after the swap, data_req at line_cnt=10 yields line_length=30 two cycles later.
- fft_mag[5]=1000 -> line_length=479 (clamp). With MAG_SHIFT=2 and fft_mag[5]=800 -> line_length=200.
- Second full frame arrives while ready=1 -> frame_drop pulses once at its sop; the displayed data after the next wrap equals the first frame.
- sop re-asserted at wr_addr=40 mid-FILL -> the write restarts at 0; ready is set only after 128 fresh samples; no frame_drop pulse.
- PEAK_HOLD_EN, DECAY=2: bin 3 values 100, then 50, 50 across successive refreshes -> line_length 100, 98, 96. A value of 120 next -> line_length=120.

Source files
------------

// File: rtl/spectrum_line_feeder.sv
// spectrum_line_feeder
//   Producer side of the LCD spectrum handshake. One FFT magnitude frame is
//   captured into the write bank while the renderer reads bars from the read
//   bank. The banks swap only when the display wraps from the last point to
//   point 0, so a displayed frame is never mixed.
//   Optional build macro: PEAK_HOLD_EN adds per-bin peak hold with decay.
module spectrum_line_feeder #(
    parameter int POINT_NUM  = 128,
    parameter int H_LCD_DISP = 480,
    parameter int MAG_SHIFT  = 0,
    parameter int DECAY      = 2
) (
    input  logic        lcd_clk,
    input  logic        sys_rst_n,
    input  logic        fft_valid,
    input  logic        fft_sop,
    input  logic [15:0] fft_mag,
    input  logic        data_req,
    input  logic        wr_over,
    output logic [6:0]  line_cnt,
    output logic [15:0] line_length,
    output logic        frame_drop
);
    localparam int          AW      = (POINT_NUM > 1) ? $clog2(POINT_NUM) : 1;
    localparam logic [6:0]  LAST_PT = 7'(POINT_NUM - 1);
    localparam logic [15:0] MAX_LEN = 16'(H_LCD_DISP - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DONE} wr_state_t;

    wr_state_t   state_q, state_d;
    logic [6:0]  wr_addr_q, wr_addr_d;
    logic        wr_bank_q, wr_bank_d;
    logic        rd_bank_q, rd_bank_d;
    logic        ready_q, ready_d;
    logic        shown_valid_q, shown_valid_d;   // read bank holds a real frame
    logic [6:0]  line_cnt_q, line_cnt_d;
    logic [15:0] line_length_q, line_length_d;
    logic        frame_drop_q, frame_drop_d;
    logic        req_q, req_d;                   // read pipeline stage-1 valid
    logic        rd_ok_q, rd_ok_d;               // the read in flight hit a real frame

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [15:0]   mem [0:2*POINT_NUM-1];
    logic [15:0]   mem_rd_data;

    logic [15:0] mag_sel;
    logic [15:0] shifted;
    logic [15:0] len_clamped;

`ifdef PEAK_HOLD_EN
    localparam logic [15:0] DECAY_W = 16'(DECAY);
    logic [15:0] peak_q [POINT_NUM];
    logic [15:0] peak_cur;
    logic [15:0] peak_d;
    logic [6:0]  rd_idx_q, rd_idx_d;
`endif

    // Write FSM, display advance and bank swap
    always_comb begin
        state_d       = state_q;
        wr_addr_d     = wr_addr_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        ready_d       = ready_q;
        shown_valid_d = shown_valid_q;
        line_cnt_d    = line_cnt_q;
        frame_drop_d  = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = '0;

        case (state_q)
            ST_FILL: begin
                if (fft_valid) begin
                    mem_we = 1'b1;
                    if (fft_sop) begin
                        // a new sop abandons the short frame without a drop pulse
                        mem_waddr = '0;
                        wr_addr_d = 7'd1;
                    end else begin
                        mem_waddr = wr_addr_q[AW-1:0];
                        if (wr_addr_q == LAST_PT) begin
                            ready_d = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            wr_addr_d = wr_addr_q + 7'd1;
                        end
                    end
                end
            end
            default: begin
                // IDLE and DONE only react to a start of frame
                if (fft_valid && fft_sop) begin
                    if (ready_q) begin
                        frame_drop_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = '0;
                        wr_addr_d = 7'd1;
                        state_d   = ST_FILL;
                    end
                end
            end
        endcase

        // ready_q is only 1 outside FILL, so this never collides with the set above
        if (wr_over) begin
            if (line_cnt_q < LAST_PT) begin
                line_cnt_d = line_cnt_q + 7'd1;
            end else begin
                line_cnt_d = '0;
                if (ready_q) begin
                    wr_bank_d     = ~wr_bank_q;
                    rd_bank_d     = ~rd_bank_q;
                    ready_d       = 1'b0;
                    shown_valid_d = 1'b1;
                end
            end
        end
    end

    // Frame banks: write port from the FFT side, registered read for the renderer
    always_ff @(posedge lcd_clk) begin
        if (mem_we) begin
            mem[{wr_bank_q, mem_waddr}] <= fft_mag;
        end
        if (data_req) begin
            mem_rd_data <= mem[{rd_bank_q, line_cnt_q[AW-1:0]}];
        end
    end

    // Read stage 1: scale, clamp and optionally apply peak hold
    always_comb begin
        req_d       = data_req;
        rd_ok_d     = data_req ? shown_valid_q : rd_ok_q;
        mag_sel     = rd_ok_q ? mem_rd_data : 16'd0;
        shifted     = mag_sel >> MAG_SHIFT;
        len_clamped = (shifted > MAX_LEN) ? MAX_LEN : shifted;
`ifdef PEAK_HOLD_EN
        rd_idx_d = data_req ? line_cnt_q : rd_idx_q;
        peak_cur = peak_q[rd_idx_q[AW-1:0]];
        if (len_clamped >= peak_cur) begin
            peak_d = len_clamped;
        end else if (peak_cur >= DECAY_W) begin
            peak_d = peak_cur - DECAY_W;
        end else begin
            peak_d = 16'd0;
        end
        line_length_d = req_q ? peak_d : line_length_q;
`else
        line_length_d = req_q ? len_clamped : line_length_q;
`endif
    end

`ifdef PEAK_HOLD_EN
    // Peak table: one entry updated per completed read
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < POINT_NUM; i++) begin
                peak_q[i] <= '0;
            end
            rd_idx_q <= '0;
        end else begin
            rd_idx_q <= rd_idx_d;
            if (req_q) begin
                peak_q[rd_idx_q[AW-1:0]] <= peak_d;
            end
        end
    end
`endif

    // Control and output registers
    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_IDLE;
            wr_addr_q     <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b1;
            ready_q       <= 1'b0;
            shown_valid_q <= 1'b0;
            line_cnt_q    <= '0;
            line_length_q <= '0;
            frame_drop_q  <= 1'b0;
            req_q         <= 1'b0;
            rd_ok_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_addr_q     <= wr_addr_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            ready_q       <= ready_d;
            shown_valid_q <= shown_valid_d;
            line_cnt_q    <= line_cnt_d;
            line_length_q <= line_length_d;
            frame_drop_q  <= frame_drop_d;
            req_q         <= req_d;
            rd_ok_q       <= rd_ok_d;
        end
    end

    assign line_cnt    = line_cnt_q;
    assign line_length = line_length_q;
    assign frame_drop  = frame_drop_q;

endmodule
